// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
package div_pkg;

  localparam int BW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int bw = 8
) (
  input  logic [bw:0]   rem,
  input  logic          bit_in,
  input  logic [bw-1:0] divisor,
  output logic [bw:0]   rem_next,
  output logic          q_bit
);

  logic signed [bw+1:0] trial;

  // rem never exceeds the divisor, so {rem, bit_in} is non-negative here
  assign trial    = $signed({rem, bit_in}) - $signed({2'b00, divisor});
  assign q_bit    = ~trial[bw+1];
  assign rem_next = q_bit ? trial[bw:0] : {rem[bw-1:0], bit_in};

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, one quotient bit per clock, MSB first.
// Optional DIV_ZERO_DETECT_EN: short-circuits B=0 and reports it on DivZero.
import div_pkg::*;

module seq_divider #(
  parameter int bw = BW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Start,
  input  logic [bw-1:0] A,
  input  logic [bw-1:0] B,
  output logic          Ready,
  output logic          Done,
  output logic [bw-1:0] Q,
  output logic [bw-1:0] R
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic          DivZero
`endif
);

  localparam int CW = $clog2(bw);

  div_state_t    state, state_nx;
  logic [bw-1:0] dvd;
  logic [bw-1:0] dvs;
  logic [bw:0]   rem;
  logic [bw:0]   rem_nx;
  logic [CW-1:0] cnt;
  logic          q_bit;
  logic          skip;

  // dvd holds the dividend; quotient bits shift in at the LSB as dividend bits leave the MSB
  div_step #(.bw(bw)) u_step (
    .rem      (rem),
    .bit_in   (dvd[bw-1]),
    .divisor  (dvs),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

`ifdef DIV_ZERO_DETECT_EN
  logic dz;
  assign skip    = dz;
  assign DivZero = dz;
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (Start) state_nx = CALC;
      CALC: if (skip || cnt == '0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (Start) begin
          dvd <= A;
          dvs <= B;
          rem <= '0;
          cnt <= CW'(bw - 1);
`ifdef DIV_ZERO_DETECT_EN
          dz  <= (B == '0);
`endif
        end
        CALC: begin
          if (skip) begin
            // divide-by-zero bypasses the iterations with the saturated result
            dvd <= '1;
            rem <= {1'b0, dvd};
          end else begin
            dvd <= {dvd[bw-2:0], q_bit};
            rem <= rem_nx;
            if (cnt != '0) cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign Ready = (state == IDLE);
  assign Done  = (state == DONE);
  assign Q     = dvd;
  assign R     = rem[bw-1:0];

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (bw=8) against an arithmetic reference.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Start;
  logic [7:0] A, B, Q, R;
  logic       Ready, Done;
`ifdef DIV_ZERO_DETECT_EN
  logic       DivZero;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  seq_divider #(.bw(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Ready   (Ready),
    .Done    (Done),
    .Q       (Q),
    .R       (R)
`ifdef DIV_ZERO_DETECT_EN
    ,
    .DivZero (DivZero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full division from an IDLE negedge; optional Start/operand glitch mid-CALC.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit glitch,
                         input string tag);
    int e;
    int lat;
    logic [7:0] eq, er;
    eq  = (b == 8'd0) ? 8'hFF : 8'(a / b);
    er  = (b == 8'd0) ? a : 8'(a % b);
    lat = 8;
`ifdef DIV_ZERO_DETECT_EN
    if (b == 8'd0) lat = 1;
`endif
    chk({tag, " ready"}, 32'(Ready), 32'd1);
    A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; A = 8'($urandom); B = 8'($urandom);
    chk({tag, " busy"}, 32'(Ready), 32'd0);
    e = 0;
    while (Done !== 1'b1 && e < 40) begin
      @(negedge clk);
      e++;
      if (glitch && e == 3) begin
        chk({tag, " glitch ready"}, 32'(Ready), 32'd0);
        A = 8'd1; B = 8'd1; Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
    end
    chk({tag, " latency"}, 32'(e), 32'(lat));
    chk({tag, " Q"}, 32'(Q), 32'(eq));
    chk({tag, " R"}, 32'(R), 32'(er));
`ifdef DIV_ZERO_DETECT_EN
    chk({tag, " divzero"}, 32'(DivZero), 32'(b == 8'd0));
`endif
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(Done), 32'd0);
    chk({tag, " idle ready"}, 32'(Ready), 32'd1);
    chk({tag, " Q hold"}, 32'(Q), 32'(eq));
    chk({tag, " R hold"}, 32'(R), 32'(er));
  endtask

  initial begin
    int e;
    logic [7:0] ra, rb;
    rst_n = 1'b0; Start = 1'b0; A = '0; B = '0;
    #1;
    chk("reset ready", 32'(Ready), 32'd1);
    chk("reset done", 32'(Done), 32'd0);
    chk("reset Q", 32'(Q), 32'd0);
    chk("reset R", 32'(R), 32'd0);
`ifdef DIV_ZERO_DETECT_EN
    chk("reset divzero", 32'(DivZero), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_div(8'd200, 8'd7, 1'b0, "d200_7");
    run_div(8'd5, 8'd9, 1'b0, "d5_9");
    run_div(8'd255, 8'd1, 1'b0, "d255_1");
    run_div(8'd200, 8'd7, 1'b1, "glitch200_7");

    // reset in the middle of a running division
    A = 8'd200; B = 8'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midcalc busy", 32'(Ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midcalc rst ready", 32'(Ready), 32'd1);
    chk("midcalc rst Q", 32'(Q), 32'd0);
    chk("midcalc rst R", 32'(R), 32'd0);
    chk("midcalc rst done", 32'(Done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midcalc no done", 32'(Done), 32'd0);
    end
    rst_n = 1'b1;
    run_div(8'd100, 8'd10, 1'b0, "d100_10");

    run_div(8'd77, 8'd0, 1'b0, "d77_0");

    // Start held high: back-to-back divisions
    A = 8'd200; B = 8'd7; Start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("b2b ready", 32'(Ready), 32'd1);
      @(negedge clk);
      chk("b2b busy", 32'(Ready), 32'd0);
      e = 0;
      while (Done !== 1'b1 && e < 40) begin
        @(negedge clk);
        e++;
        if (Done !== 1'b1) chk("b2b no ready", 32'(Ready), 32'd0);
      end
      chk("b2b latency", 32'(e), 32'd8);
      chk("b2b Q", 32'(Q), 32'd28);
      chk("b2b R", 32'(R), 32'd4);
      chk("b2b done ready", 32'(Ready), 32'd0);
      @(negedge clk);
      chk("b2b done pulse", 32'(Done), 32'd0);
    end
    Start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom);
      rb = (i % 4 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
      if (i % 3 == 0) rb = 8'($urandom_range(1, 15));
      run_div(ra, rb, 1'b0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
